fetch_pc_stage: RTL
===================

// Module: fetch_pc_stage
// PURPOSE
//  F-stage PC register plus F/D pipeline register. Sits directly downstream of the next-PC logic.
//  Each cycle it latches the selected next PC as F_PC and drives the instruction-memory address.
//  It captures the fetched word into D and detects fetch-address exceptions (AdEL).
//  It also tags delay-slot instructions (BD) and applies exception redirect, eret squash and stall.
// PARAMETERS
//  RESET_PC     32'h0000_3000  F_PC value after reset
//  EXC_ENTRY    32'h0000_4180  handler entry; PC of flushed D bubbles
//  IM_BASE      32'h0000_3000  lowest legal fetch address
//  IM_LAST      32'h0000_6ffc  highest legal fetch address
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high
//  NPC          in   32  next PC from next-PC logic (already resolves req/eret/jump/branch)
//  stall        in   1   hazard-unit freeze of F and D
//  req          in   1   exception/interrupt taken this cycle; flush
//  eret_D       in   1   eret currently in D
//  D_is_jump    in   1   D holds a branch/jump; the F word is its delay slot
//  i_inst_rdata in   32  combinational IM read data for i_inst_addr
//  i_inst_addr  out  32  = F_PC
//  F_PC         out  32  current fetch PC
//  D_PC         out  32  PC of instruction in D
//  D_Instr      out  32  instruction word in D (0 = nop)
//  D_BD         out  1   D instruction is in a delay slot
//  D_ExcCode    out  5   fetch exception carried to D (0 none, 4 AdEL)
// BEHAVIOUR
//  - Reset (async, immediate): F_PC=RESET_PC, D_PC=RESET_PC, D_Instr=0, D_BD=0, D_ExcCode=0.
//  - Priority at each posedge: reset > req > stall > eret_D squash > normal advance.
//  - req=1 (overrides stall): F_PC<=NPC (=EXC_ENTRY from next-PC logic); D_PC<=EXC_ENTRY;
//    D_Instr<=0, D_BD<=0, D_ExcCode<=0.
//  - stall=1, req=0: F_PC and all D_* hold their values; F_ExcCode is recomputed, never latched.
//  - eret_D=1, stall=0: F_PC<=NPC; D<=bubble: D_PC<=F_PC, D_Instr=0, D_BD=0, D_ExcCode=0.
//    Squashed word and any AdEL it raised are discarded.
//  - Normal advance: F_PC<=NPC; D_PC<=F_PC; D_BD<=D_is_jump; D_ExcCode<=F_ExcCode.
//    D_Instr<=(F_ExcCode!=0) ? 0 : i_inst_rdata.
//  - AdEL (F_ExcCode=4) when F_PC[1:0]!=0, or F_PC<IM_BASE, or F_PC>IM_LAST (unsigned compare).
//  - BD with eret_D: eret has no delay slot; squash wins and D_BD=0.
//  - No wrap handling: F_PC is exactly NPC, full 32 bits; out-of-range values raise AdEL.
//  - Latency: NPC -> F_PC 1 cycle; F word -> D 1 cycle. No combinational path from inputs to D_*.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds output perf_fetch_cnt (32 bits, reset 0).
//    Increments by 1 on each cycle that latches a real word into D: normal advance with F_ExcCode==0.
//    Does not count on stall, req, eret squash or AdEL. Wraps 0xffffffff -> 0.
//  FETCH_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Shared defines header: ExcCode values (EXC_NONE=0, EXC_ADEL=4), RESET_PC/EXC_ENTRY/IM range defaults.
//  - One sub-module, fetch_addr_check: combinational F_PC -> F_ExcCode range/alignment check.
//  - Top holds the PC register, the F/D register and the optional counter.
// TESTING
//  1 Reset released, stall=0, NPC=F_PC+4 -> F_PC 3000,3004,3008. D_PC lags one cycle; D_Instr = IM words.
//  2 NPC=32'h0000_3002 -> next cycle F_ExcCode=4. Following edge: D_ExcCode=4, D_Instr=0, D_PC=3002.
//  3 stall=1 for 3 cycles with req=1 in cycle 2 -> F_PC=4180, D_PC=4180, D_Instr=0 after cycle 2.
//    Holds in cycle 3.
//  4 D_is_jump=1 at D_PC=3010 -> next edge D_PC=3014, D_BD=1; following instruction D_BD=0.
//  5 eret_D=1, stall=0, F_PC=3020 -> D_PC=3020, D_Instr=0, D_BD=0. F_PC=NPC (EPC+4).
//    With stall=1 the same cycle: D holds the eret.
//  6 FETCH_PERF_CNT_EN: 10 advances, 2 stalls, 1 AdEL, 1 req -> perf_fetch_cnt=9.
//    Async reset mid-run -> all outputs to reset values immediately.

Source files
------------

// File: rtl/fetch_pc_stage_pkg.sv
// fetch_pc_stage_pkg
//   Shared definitions for the fetch PC stage:
//     - fetch exception codes carried into D (EXC_NONE, EXC_ADEL)
//     - default reset PC, exception handler entry and legal IM range
//   Imported by fetch_pc_stage and fetch_addr_check.
package fetch_pc_stage_pkg;

  localparam int unsigned EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_LAST   = 32'h0000_6ffc;

endpackage

// File: rtl/fetch_pc_stage_addr_check.sv
// fetch_addr_check
//   Purely combinational fetch-address check. Flags AdEL when the fetch PC
//   is not word aligned or lies outside [IM_BASE, IM_LAST] (unsigned).
// Ports
//   pc        in   32  current fetch PC
//   exc_code  out  5   EXC_ADEL on a bad fetch address, else EXC_NONE
module fetch_addr_check
  import fetch_pc_stage_pkg::*;
#(
  parameter logic [31:0] IM_BASE = DEF_IM_BASE,
  parameter logic [31:0] IM_LAST = DEF_IM_LAST
) (
  input  logic [31:0] pc,
  output logic [4:0]  exc_code
);

  logic misaligned;
  logic out_of_range;

  always_comb begin
    misaligned   = (pc[1:0] != 2'b00);
    out_of_range = (pc < IM_BASE) || (pc > IM_LAST);
    exc_code     = (misaligned || out_of_range) ? EXC_ADEL : EXC_NONE;
  end

endmodule

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage
//   F-stage PC register plus the F/D pipeline register. Latches the selected
//   next PC into F_PC, presents it as the instruction-memory address, and
//   captures the fetched word (or a bubble) into D together with the
//   delay-slot tag and any fetch-address exception.
//
//   Update priority at each rising edge:
//     reset (async) > req flush > stall hold > eret_D squash > normal advance
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   asynchronous, active-high
//   NPC           in   32  next PC (already resolved by next-PC logic)
//   stall         in   1   freeze F and D
//   req           in   1   exception/interrupt taken; flushes D, wins over stall
//   eret_D        in   1   eret in D; the F word is squashed
//   D_is_jump     in   1   D holds a branch/jump; F word is its delay slot
//   i_inst_rdata  in   32  combinational IM read data for i_inst_addr
//   i_inst_addr   out  32  instruction-memory address (= F_PC)
//   F_PC          out  32  current fetch PC
//   D_PC          out  32  PC of the instruction in D
//   D_Instr       out  32  instruction word in D (0 = nop)
//   D_BD          out  1   D instruction sits in a delay slot
//   D_ExcCode     out  5   fetch exception carried to D (0 none, 4 AdEL)
//   perf_fetch_cnt out 32  real words latched into D (only with FETCH_PERF_CNT_EN)
//
// Configuration macro: FETCH_PERF_CNT_EN adds the perf_fetch_cnt counter/port.
module fetch_pc_stage
  import fetch_pc_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] EXC_ENTRY = DEF_EXC_ENTRY,
  parameter logic [31:0] IM_BASE   = DEF_IM_BASE,
  parameter logic [31:0] IM_LAST   = DEF_IM_LAST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_D,
  input  logic        D_is_jump,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_BD,
  output logic [4:0]  D_ExcCode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt
`endif
);

  logic [4:0] f_exc_code;

  fetch_addr_check #(
    .IM_BASE (IM_BASE),
    .IM_LAST (IM_LAST)
  ) u_addr_check (
    .pc       (F_PC),
    .exc_code (f_exc_code)
  );

  assign i_inst_addr = F_PC;

  // PC register and F/D register share one priority chain so that a flush,
  // hold or squash can never leave F and D out of step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_PC      <= RESET_PC;
      D_PC      <= RESET_PC;
      D_Instr   <= 32'h0;
      D_BD      <= 1'b0;
      D_ExcCode <= EXC_NONE;
    end else if (req) begin
      // Flush: D becomes a bubble tagged with the handler entry PC.
      F_PC      <= NPC;
      D_PC      <= EXC_ENTRY;
      D_Instr   <= 32'h0;
      D_BD      <= 1'b0;
      D_ExcCode <= EXC_NONE;
    end else if (stall) begin
      F_PC      <= F_PC;
      D_PC      <= D_PC;
      D_Instr   <= D_Instr;
      D_BD      <= D_BD;
      D_ExcCode <= D_ExcCode;
    end else if (eret_D) begin
      // eret has no delay slot: the word after it is dropped along with any
      // AdEL it raised, and the bubble keeps the squashed PC.
      F_PC      <= NPC;
      D_PC      <= F_PC;
      D_Instr   <= 32'h0;
      D_BD      <= 1'b0;
      D_ExcCode <= EXC_NONE;
    end else begin
      F_PC      <= NPC;
      D_PC      <= F_PC;
      D_Instr   <= (f_exc_code != EXC_NONE) ? 32'h0 : i_inst_rdata;
      D_BD      <= D_is_jump;
      D_ExcCode <= f_exc_code;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Counts only cycles that put a genuine instruction word into D.
  logic count_en;
  assign count_en = !req && !stall && !eret_D && (f_exc_code == EXC_NONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= 32'h0;
    end else if (count_en) begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
    end
  end
`endif

endmodule
